// File: rtl/tenkey_debounce_if.sv
// Ten-key pad bundle: raw switches in, debounced key vector and strobes out.
// No latency of its own; it only groups signals.
// No backpressure: strobes are fire-and-forget, consumers must sample them.
interface tenkey_debounce_if;
    logic [9:0] sw_raw;
    logic [9:0] tenkey;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_err;

    // Debouncer side: consumes switches, produces the clean key stream.
    modport master (
        input  sw_raw,
        output tenkey,
        output key_valid,
        output key_code,
        output key_err
    );

    // Consumer side: drives switches (pad or bench), observes the key stream.
    modport slave (
        output sw_raw,
        input  tenkey,
        input  key_valid,
        input  key_code,
        input  key_err
    );
endinterface

// File: rtl/tenkey_debounce.sv
// Ten-key debouncer: sync, slow sampling, chatter/multi-key rejection, one-hot out.
// Latency: 2 sync cycles + up to CLK_DIV tick phase + DEBOUNCE_N ticks per press.
// No backpressure: key_valid/key_err are single-cycle strobes on tick cycles.
module tenkey_debounce #(
    parameter int CLK_DIV    = 532000,
    parameter int DEBOUNCE_N = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic          osc_clk,
    input  logic          reset,
    tenkey_debounce_if.master kif
);

    localparam int         PW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);
    localparam logic [3:0] DN     = 4'(DEBOUNCE_N);
    // Raw level of a released switch; also the sync flops' reset value.
    localparam logic [9:0] INV    = (ACTIVE_LOW != 0) ? 10'h3FF : 10'h000;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PRESS_CHK   = 3'd1,
        HELD        = 3'd2,
        RELEASE_CHK = 3'd3,
        LOCKOUT     = 3'd4
    } state_t;

    function automatic logic is_onehot(input logic [9:0] v);
        return (v != 10'h000) && ((v & (v - 10'd1)) == 10'h000);
    endfunction

    function automatic logic [3:0] encode(input logic [9:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) c = 4'(i);
        end
        return c;
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [9:0]    sync1_q, sync2_q;
    state_t        state_q, state_d;
    logic [9:0]    cand_q, cand_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [9:0]    tenkey_q, tenkey_d;
    logic [3:0]    key_code_q, key_code_d;

    logic          tick;
    logic [9:0]    s;
    logic [3:0]    cnt_inc;
    logic          judge;
    logic [9:0]    judge_vec;
    logic          accept;
    logic          reject;

    assign tick    = (presc_q == PMAX);
    assign s       = sync2_q ^ INV;
    assign cnt_inc = cnt_q + 4'd1;

    // Prescaler next value: free-running 0..CLK_DIV-1.
    always_comb begin
        presc_d = presc_q + PW'(1);
        if (tick) presc_d = '0;
    end

    // Prescaler register.
    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) presc_q <= '0;
        else       presc_q <= presc_d;
    end

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            sync1_q <= INV;
            sync2_q <= INV;
        end else begin
            sync1_q <= kif.sw_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce FSM next state; a candidate that survives DEBOUNCE_N samples
    // is "judged": one-hot is accepted, anything else is rejected as a chord.
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        tenkey_d   = tenkey_q;
        key_code_d = key_code_q;
        judge      = 1'b0;
        judge_vec  = cand_q;
        accept     = 1'b0;
        reject     = 1'b0;

        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (s != 10'h000) begin
                        cand_d    = s;
                        cnt_d     = 4'd1;
                        state_d   = PRESS_CHK;
                        judge_vec = s;
                        judge     = (DN == 4'd1);
                    end
                end
                PRESS_CHK: begin
                    if (s == cand_q) begin
                        cnt_d = cnt_inc;
                        judge = (cnt_inc >= DN);
                    end else if (s == 10'h000) begin
                        state_d = IDLE;
                    end else begin
                        cand_d    = s;
                        cnt_d     = 4'd1;
                        judge_vec = s;
                        judge     = (DN == 4'd1);
                    end
                end
                HELD: begin
                    if (s != cand_q) begin
                        cnt_d   = 4'd1;
                        state_d = RELEASE_CHK;
                        // A single-sample debounce releases straight away.
                        if (DN == 4'd1) begin
                            tenkey_d = 10'h000;
                            cnt_d    = 4'd0;
                            state_d  = (s == 10'h000) ? IDLE : LOCKOUT;
                        end
                    end
                end
                RELEASE_CHK: begin
                    if (s == cand_q) begin
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DN) begin
                            tenkey_d = 10'h000;
                            cnt_d    = 4'd0;
                            state_d  = (s == 10'h000) ? IDLE : LOCKOUT;
                        end
                    end
                end
                LOCKOUT: begin
                    if (s != 10'h000) begin
                        cnt_d = 4'd0;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DN) begin
                            cnt_d   = 4'd0;
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d  = IDLE;
                    cnt_d    = 4'd0;
                    tenkey_d = 10'h000;
                end
            endcase

            if (judge) begin
                if (is_onehot(judge_vec)) begin
                    accept     = 1'b1;
                    tenkey_d   = judge_vec;
                    key_code_d = encode(judge_vec);
                    state_d    = HELD;
                end else begin
                    reject  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = LOCKOUT;
                end
            end
        end
    end

    // FSM and output registers.
    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cand_q     <= 10'h000;
            cnt_q      <= 4'd0;
            tenkey_q   <= 10'h000;
            key_code_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            tenkey_q   <= tenkey_d;
            key_code_q <= key_code_d;
        end
    end

    // Strobes fire on the deciding tick itself; key_code is bypassed so it
    // already carries the new code while key_valid is high.
    always_comb begin
        kif.tenkey    = tenkey_q;
        kif.key_valid = accept;
        kif.key_err   = reject;
        kif.key_code  = accept ? key_code_d : key_code_q;
    end

endmodule
